// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and op-class predicates for the multiply/divide unit.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU codes to the multiply class.
package mdu_pkg;

  localparam int CNT_W = 5;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MFHI  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;
  localparam logic [3:0] OP_NOP   = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2
  } mdu_state_e;

  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU signal bundle; the pipeline side is master, the MDU is slave.
interface mdu_if;
  import mdu_pkg::*;

  // start qualifies mdu_op for one cycle and is accepted only while busy is low;
  // stall_req tells the hazard unit to hold back any further MDU op.
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_data;
  mdu_state_e  state_dbg;

  modport master (
    output start, mdu_op, A, B,
    input  busy, stall_req, rd_data, state_dbg
  );

  modport slave (
    input  start, mdu_op, A, B,
    output busy, stall_req, rd_data, state_dbg
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply/divide result ({hi,lo}) plus a write-enable that drops on divide-by-zero.
// With MDU_MADD_EN the accumulate variants fold the current {HI,LO} in.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  output logic [63:0] res,
  output logic        res_we
);

  logic signed [63:0] a_s;
  logic signed [63:0] b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_sdiv;
  logic [31:0]        b_udiv;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  always_comb begin
    a_s    = {{32{a[31]}}, a};
    b_s    = {{32{b[31]}}, b};
    prod_s = a_s * b_s;
    prod_u = {32'd0, a} * {32'd0, b};
    // Dividing by 1 covers both the discarded zero-divisor case and the
    // INT_MIN / -1 overflow, whose required result is exactly {0, A}.
    b_sdiv = ((b == 32'd0) || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : b;
    b_udiv = (b == 32'd0) ? 32'd1 : b;
    q_s    = $signed(a) / $signed(b_sdiv);
    r_s    = $signed(a) % $signed(b_sdiv);
    q_u    = a / b_udiv;
    r_u    = a % b_udiv;

    res    = 64'd0;
    res_we = 1'b0;
    case (op)
      OP_MULT:  begin res = prod_s;     res_we = 1'b1; end
      OP_MULTU: begin res = prod_u;     res_we = 1'b1; end
      OP_DIV:   begin res = {r_s, q_s}; res_we = (b != 32'd0); end
      OP_DIVU:  begin res = {r_u, q_u}; res_we = (b != 32'd0); end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res = acc + prod_s; res_we = 1'b1; end
      OP_MADDU: begin res = acc + prod_u; res_we = 1'b1; end
      OP_MSUB:  begin res = acc - prod_s; res_we = 1'b1; end
      OP_MSUBU: begin res = acc - prod_u; res_we = 1'b1; end
`endif
      default:  begin res = 64'd0;      res_we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// HI/LO multiply/divide unit: FSM, cycle counter and HI/LO pair; result is latched at start
// and committed on the edge leaving RUN. MDU_MADD_EN enables the MADD/MSUB family.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset_n,
  mdu_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             res_we_q, res_we_d;

  logic [63:0]      calc_res;
  logic             calc_we;

  mdu_calc u_calc (
    .op     (bus.mdu_op),
    .a      (bus.A),
    .b      (bus.B),
`ifdef MDU_MADD_EN
    .acc    ({hi_q, lo_q}),
`endif
    .res    (calc_res),
    .res_we (calc_we)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      res_we_q <= res_we_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_we_d = res_we_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (is_mul(bus.mdu_op)) begin
            state_d              = ST_MUL_RUN;
            cnt_d                = MUL_LOAD;
            {res_hi_d, res_lo_d} = calc_res;
            res_we_d             = calc_we;
          end else if (is_div(bus.mdu_op)) begin
            state_d              = ST_DIV_RUN;
            cnt_d                = DIV_LOAD;
            {res_hi_d, res_lo_d} = calc_res;
            res_we_d             = calc_we;
          end else if (bus.mdu_op == OP_MTHI) begin
            hi_d = bus.A;
          end else if (bus.mdu_op == OP_MTLO) begin
            lo_d = bus.A;
          end
        end
      end
      ST_MUL_RUN, ST_DIV_RUN: begin
        // Starts arriving here are ignored; HI/LO only move on the final edge.
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (res_we_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rd_data = 32'd0;
    if (bus.start) begin
      if (bus.mdu_op == OP_MFHI) bus.rd_data = hi_q;
      else if (bus.mdu_op == OP_MFLO) bus.rd_data = lo_q;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.stall_req = bus.busy | (bus.start & (is_mul(bus.mdu_op) | is_div(bus.mdu_op)));
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: reset abort, mul/div results and busy lengths, HI/LO moves,
// ignored starts while busy, and the MDU_MADD_EN accumulate ops.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [31:0] v;
  logic        stall_seen;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Holds start for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
    #1 stall_seen = bus.stall_req;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
  endtask

  task automatic read_reg(input logic [3:0] op, output logic [31:0] val);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    #1 val = bus.rd_data;
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] r;
    read_reg(OP_MFHI, r);
    check({tag, "_hi"}, r, exp_hi);
    read_reg(OP_MFLO, r);
    check({tag, "_lo"}, r, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_hilo("rst", 32'd0, 32'd0);
    reset_n = 1'b1;

    // Reset aborting a DIV in its third busy cycle
    issue(OP_MTHI, 32'hAAAA_5555, 32'd0);
    issue(OP_MTLO, 32'h5555_AAAA, 32'd0);
    check_hilo("mt_pre_rst", 32'hAAAA_5555, 32'h5555_AAAA);
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    check("div_busy_c3", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_hilo("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(OP_MFHI, v);
    check("post_rst_hi", v, 32'd0);

    // MULT -2 * 3
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_stall_req", 32'(stall_seen), 32'd1);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULTU with an old-LO read and an ignored start while busy
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    read_reg(OP_MFLO, v);
    check("mflo_during_busy", v, 32'hFFFF_FFFA);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = OP_MULT;
    bus.A      = 32'd5;
    bus.B      = 32'd5;
    #1 check("stall_while_busy", 32'(bus.stall_req), 32'd1);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mdu_op = OP_NOP;
    wait_idle(n);
    check("multu_busy_remaining", 32'(n), 32'd3);
    check_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    // Divides
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    check_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    check("divu_zero_busy_cycles", 32'(n), 32'd10);
    check_hilo("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);

    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check_hilo("div_negdiv", 32'h0000_0001, 32'hFFFF_FFFD);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_idle(n);
    check_hilo("divu", 32'h0000_0002, 32'h0000_000E);

    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle(n);
    check_hilo("mult_min", 32'h4000_0000, 32'h0000_0000);

    // Single-cycle moves and a NOP code
    issue(OP_MTLO, 32'h1234_5678, 32'd0);
    check("mtlo_stall_req", 32'(stall_seen), 32'd0);
    check("mtlo_busy", 32'(bus.busy), 32'd0);
    read_reg(OP_MFLO, v);
    check("mtlo_readback", v, 32'h1234_5678);
    issue(OP_MTHI, 32'hCAFE_F00D, 32'd0);
    read_reg(OP_MFHI, v);
    check("mthi_readback", v, 32'hCAFE_F00D);

    issue(4'd13, 32'd9, 32'd9);
    check("nop_stall_req", 32'(stall_seen), 32'd0);
    check("nop_busy", 32'(bus.busy), 32'd0);
    read_reg(4'd13, v);
    check("nop_rd_data", v, 32'd0);

    // Accumulate ops
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
    issue(OP_MADDU, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu_stall_req", 32'(stall_seen), 32'd1);
    wait_idle(n);
    check("maddu_busy_cycles", 32'(n), 32'd5);
    check_hilo("maddu", 32'h0000_0001, 32'h0000_0000);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    wait_idle(n);
    check("msub_busy_cycles", 32'(n), 32'd5);
    check_hilo("msub", 32'h0000_0001, 32'h0000_0001);
`else
    check("maddu_stall_req", 32'(stall_seen), 32'd0);
    wait_idle(n);
    check("maddu_busy_cycles", 32'(n), 32'd0);
    check_hilo("maddu", 32'h0000_0000, 32'hFFFF_FFFF);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    wait_idle(n);
    check("msub_busy_cycles", 32'(n), 32'd0);
    check_hilo("msub", 32'h0000_0000, 32'hFFFF_FFFF);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
